// File: rtl/mem_arbiter.sv
// Arbitrates the single-port memory between the read-only fetch port and the
// read/write data port, sequencing one transaction at a time (IDLE/ISSUE/WAIT/DONE).
module mem_arbiter #(
  parameter int DATA_W     = 19,
  parameter int ADDR_W     = 19,
  parameter int MEM_LAT    = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam int CNT_W = 3;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sel_data_q, sel_data_d;
  logic              we_q, we_d;
  logic              last_data_q, last_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_stb_q, rd_stb_d;
  logic              wr_stb_q, wr_stb_d;
  logic              if_gnt_q, if_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              pick_data;

  // A lone requester always wins; ties go to the data port under fixed
  // priority, otherwise to whichever port did not win the previous grant.
  function automatic logic arb_pick_data(input logic if_r, input logic d_r,
                                         input logic last_data);
    if (d_r && !if_r) return 1'b1;
    if (if_r && !d_r) return 1'b0;
    if (FIXED_PRIO != 0) return 1'b1;
    return !last_data;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_data_d  = sel_data_q;
    we_d        = we_q;
    last_data_d = last_data_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    rd_stb_d    = 1'b0;
    wr_stb_d    = 1'b0;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    pick_data   = arb_pick_data(if_req, d_req, last_data_q);

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          sel_data_d  = pick_data;
          last_data_d = pick_data;
          state_d     = S_ISSUE;
          if (pick_data) begin
            addr_d   = d_addr;
            wdata_d  = d_wdata;
            we_d     = d_we;
            d_gnt_d  = 1'b1;
            wr_stb_d = d_we;
            rd_stb_d = !d_we;
          end else begin
            addr_d   = if_addr;
            we_d     = 1'b0;
            if_gnt_d = 1'b1;
            rd_stb_d = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        if (we_q) begin
          state_d  = S_DONE;
          d_done_d = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (sel_data_q) begin
            d_rdata_d = mem_read_data;
            d_done_d  = 1'b1;
          end else begin
            if_rdata_d = mem_read_data;
            if_done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sel_data_q  <= 1'b0;
      we_q        <= 1'b0;
      last_data_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_stb_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_data_q  <= sel_data_d;
      we_q        <= we_d;
      last_data_q <= last_data_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_stb_q    <= rd_stb_d;
      wr_stb_q    <= wr_stb_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_gnt         = if_gnt_q;
  assign if_done        = if_done_q;
  assign if_rdata       = if_rdata_q;
  assign d_gnt          = d_gnt_q;
  assign d_done         = d_done_q;
  assign d_rdata        = d_rdata_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_read       = rd_stb_q;
  assign mem_write      = wr_stb_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port MemoryInterface between the CPU's instruction-fetch path (read-only) and its load/store path (read/write). Each requester uses a req/gnt/done handshake. The block arbitrates, sequences one memory transaction at a time, and returns read data to the winner. It sits between TopLevelCPU's fetch/memory stages and MemoryInterface.

Parameters:
DATA_W, 19, data width of all data buses
ADDR_W, 19, address width
MEM_LAT, 1, cycles from the read strobe cycle to valid mem_read_data (legal 1..4)
FIXED_PRIO, 0, 0 = round-robin; 1 = data port always wins ties

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch requests a read
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle pulse: fetch request accepted
if_done  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetch read data
d_req  in  1  data port requests a transfer
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_gnt  out  1  one-cycle pulse: data request accepted
d_done  out  1  one-cycle pulse: transfer complete; d_rdata valid if read
d_rdata  out  DATA_W  data read data
mem_address  out  ADDR_W  to MemoryInterface.address
mem_write_data  out  DATA_W  to MemoryInterface.write_data
mem_write  out  1  to MemoryInterface.mem_write
mem_read  out  1  to MemoryInterface.mem_read
mem_read_data  in  DATA_W  from MemoryInterface.read_data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, wins over everything): state = IDLE; all outputs = 0, including rdata and mem_* buses; the round-robin pointer is set so the data port wins the first tie. An in-flight transaction is abandoned, with no done pulse.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: requests are sampled only in this state.
  - If any req is high at the edge, pick a winner and latch its address, write data, and we (fetch is always a read).
  - Pulse the winner's gnt for the next cycle and go to ISSUE.
  - If no req is high, stay in IDLE.
- Arbitration:
  - FIXED_PRIO = 1: d_req beats if_req.
  - FIXED_PRIO = 0: on a tie, the port that did not win the last grant wins. A single requester always wins. The pointer updates only on a grant.
- ISSUE (1 cycle): mem_read or mem_write is high for exactly this cycle. For a write, go to DONE. For a read, go to WAIT.
- WAIT (MEM_LAT cycles): count down. At the edge ending the last WAIT cycle, capture mem_read_data into the winner's rdata register, then go to DONE.
- DONE (1 cycle): pulse the winner's done, then return to IDLE.
- Latency, counted from the IDLE edge that samples req:
  - write: gnt in cycle 1, strobe in cycle 1, done in cycle 2
  - read: gnt in cycle 1, strobe in cycle 1, done in cycle 2 + MEM_LAT
- Throughput: one transaction per 3 cycles (write) or 3 + MEM_LAT cycles (read). The IDLE cycle between transactions is mandatory.
- Address and data buses:
  - mem_address and mem_write_data hold the latched values from grant until the next grant.
  - Strobes are never both high.
  - Strobes are low outside ISSUE.
- Requester rules:
  - Hold req, addr, we, and wdata stable until gnt is seen.
  - Deassert req in the cycle after gnt unless another transfer is wanted.
  - Inputs are not sampled after grant.
  - Req pulses that occur while busy and are gone by IDLE are ignored. No error is raised.
- rdata registers hold their value until the next read completion on the same port. Writes never change d_rdata.
- gnt and done are never high for both ports in the same cycle.

Test Plan:
1. d_req with d_we=1, d_addr=0, d_wdata=42 -> d_gnt in cycle 1, mem_write=1 with mem_address=0 in cycle 1, d_done in cycle 2. Then a read of addr 0 -> d_done in cycle 3 with d_rdata=42.
2. if_req and d_req held high together, round-robin -> grants go d, if, d, if. Each if_done carries the memory word at if_addr. busy drops only between transactions.
3. FIXED_PRIO=1, both requests held high for 4 transactions -> 4 data grants and zero fetch grants. Drop d_req -> the fetch is granted at the next IDLE.
4. MEM_LAT=3, fetch read of addr 5 holding value 7 -> mem_read high only in cycle 1, if_done in cycle 5 with if_rdata=7.
5. reset asserted during WAIT -> the next cycle has state IDLE, all strobes, gnt and done low, rdata=0, and no done ever appears for the aborted read.
6. Write 0x7FFFF to max address 0x7FFFF, then read it back -> d_rdata=0x7FFFF. if_rdata is unchanged by the write.
